dmem_access_ctrl: RTL

- Sequences and shares the data memory between two requesters: port 0 (core load/store) and port 1 (debug/DMA, word-only).
- Arbitrates, then drives the synchronous data memory:
  - byte address
  - 4-bit byte-lane write strobe, shifted write data
  - sign/zero extension of the returned load data
- Sits between the execute/memory stage and the data memory.
- Replaces the ad-hoc combinational lane handling with a registered, handshaked sequencer.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 61 ++++++
 rtl/dmem_access_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access sequencer.
// The core LSU and the debug/DMA port share one data memory.
package dmem_pkg;

    localparam int DM_AW = 9;
    localparam int XLEN  = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_LOAD_WAIT,
        S_RESP
    } dmem_state_e;

    typedef struct packed {
        logic             we;
        logic [2:0]       funct3;
        logic [DM_AW-1:0] addr;
        logic [XLEN-1:0]  wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane handling for RV32 loads/stores: store strobe and shift,
// load lane extract and sign/zero extension, misalignment detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      strb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            mis_o
);

    logic [XLEN-1:0] lane;
    logic            bad_f3;
    logic            mis_h;
    logic            mis_w;

    always_comb begin
        bad_f3 = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
        mis_h  = (funct3_i[1:0] == 2'b01) && off_i[0];
        mis_w  = (funct3_i[1:0] == 2'b10) && (off_i != 2'b00);
        mis_o  = bad_f3 || mis_h || mis_w;
    end

    always_comb begin
        strb_o  = 4'b1111;
        wdata_o = wdata_i;
        unique case (funct3_i[1:0])
            2'b00: begin
                strb_o  = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                strb_o  = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                strb_o  = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend.
    always_comb begin
        lane    = rdata_i >> {off_i, 3'b000};
        rdata_o = '0;
        unique case (funct3_i)
            F3_LB:   rdata_o = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   rdata_o = {{16{lane[15]}}, lane[15:0]};
            F3_LW:   rdata_o = lane;
            F3_LBU:  rdata_o = {24'b0, lane[7:0]};
            F3_LHU:  rdata_o = {16'b0, lane[15:0]};
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port data-memory sequencer: arbitrates core and debug requests
// and runs one registered, handshaked access at a time.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = DM_AW,
    parameter int DATA_W     = XLEN,
    parameter int DBG_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [2:0]            p0_funct3,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_err,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_wr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int SCW = $clog2(DBG_STARVE + 1);

    dmem_state_e       state_q;
    dmem_req_t         req_q;
    dmem_req_t         req_d;
    dmem_req_t         al_req;
    logic              port_q;
    logic              gnt1;
    logic              idle;
    logic [SCW-1:0]    starve_q;
    logic [3:0]        mem_wr_q;
    logic [3:0]        al_strb;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;
    logic              err_q;
    logic              rvalid_q;
    logic              al_mis;

    assign idle     = (state_q == S_IDLE);
    assign gnt1     = p1_valid &&
                      (!p0_valid || (starve_q == SCW'(DBG_STARVE)));
    assign p0_ready = idle && p0_valid && !gnt1;
    assign p1_ready = idle && gnt1;

    // Debug port is word-only, so its funct3 is fixed to LW.
    always_comb begin
        req_d = '{we: p0_we, funct3: p0_funct3,
                  addr: p0_addr, wdata: p0_wdata};
        if (gnt1) begin
            req_d = '{we: p1_we, funct3: F3_LW,
                      addr: p1_addr, wdata: p1_wdata};
        end
        al_req = idle ? req_d : req_q;
    end

    dmem_lane_align u_align (
        .funct3_i (al_req.funct3),
        .off_i    (al_req.addr[1:0]),
        .wdata_i  (al_req.wdata),
        .rdata_i  (mem_rdata),
        .strb_o   (al_strb),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata),
        .mis_o    (al_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            port_q      <= 1'b0;
            starve_q    <= '0;
            mem_wr_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            mem_wr_q <= '0;
            if (!p1_valid || p1_ready) begin
                starve_q <= '0;
            end else if (p0_ready) begin
                starve_q <= starve_q + SCW'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (p0_ready || p1_ready) begin
                        req_q   <= req_d;
                        port_q  <= gnt1;
                        rdata_q <= '0;
                        err_q   <= al_mis;
                        if (al_mis) begin
                            state_q  <= S_RESP;
                            rvalid_q <= 1'b1;
                        end else begin
                            state_q <= S_ACCESS;
                            if (req_d.we) begin
                                mem_wr_q    <= al_strb;
                                mem_wdata_q <= al_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (req_q.we) begin
                        state_q  <= S_RESP;
                        rvalid_q <= 1'b1;
                    end else begin
                        state_q <= S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                    rdata_q  <= al_rdata;
                    state_q  <= S_RESP;
                    rvalid_q <= 1'b1;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = {req_q.addr[DM_ADDRESS-1:2], 2'b00};
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

    assign p0_rvalid = rvalid_q && !port_q;
    assign p1_rvalid = rvalid_q && port_q;
    assign p0_rdata  = port_q ? '0 : rdata_q;
    assign p1_rdata  = port_q ? rdata_q : '0;
    assign p0_err    = err_q && !port_q;
    assign p1_err    = err_q && port_q;

endmodule
